// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared types and helpers for the frame renderer
package render_pkg;

    localparam int OBJ_COORD_W = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    localparam pixel_t BG_DEFAULT = 12'h000;

    typedef struct packed {
        logic                   en;
        logic [OBJ_COORD_W-1:0] x;
        logic [OBJ_COORD_W-1:0] y;
        logic [OBJ_COORD_W-1:0] w;
        logic [OBJ_COORD_W-1:0] h;
        pixel_t                 color;
    } obj_t;

    typedef enum logic [1:0] {
        LATCH     = 2'd0,
        RENDER    = 2'd1,
        WAIT_SWAP = 2'd2
    } render_state_t;

    // Counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/obj_hit_test.sv
// rtl/obj_hit_test.sv - combinational rectangle hit test with highest-index priority
module obj_hit_test
    import render_pkg::*;
#(
    parameter int NUM_OBJ = 8,
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  obj_t               objs_i [NUM_OBJ],
    output logic               hit_o,
    output pixel_t             color_o
);

    // Ascending scan so a later (higher-index) hit overrides earlier ones;
    // right/bottom edges are summed one bit wider so they never wrap.
    always_comb begin
        hit_o   = 1'b0;
        color_o = BG_DEFAULT;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (objs_i[i].en &&
                (x_i >= objs_i[i].x) &&
                ({1'b0, x_i} < ({1'b0, objs_i[i].x} + {1'b0, objs_i[i].w})) &&
                (y_i >= objs_i[i].y) &&
                ({1'b0, y_i} < ({1'b0, objs_i[i].y} + {1'b0, objs_i[i].h}))) begin
                hit_o   = 1'b1;
                color_o = objs_i[i].color;
            end
        end
    end

endmodule

// File: rtl/frame_renderer.sv
// rtl/frame_renderer.sv - rasterises latched rectangles into the back framebuffer half
module frame_renderer
    import render_pkg::*;
#(
    parameter int FB_W    = 640,
    parameter int FB_H    = 480,
    parameter int NUM_OBJ = 8,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 19
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       refresh,
    input  logic [11:0]                bg_color,
    input  logic [NUM_OBJ-1:0]         obj_en,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_x,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_y,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_w,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_h,
    input  logic [NUM_OBJ*12-1:0]      obj_color,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic                       wr_buf,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [11:0]                wr_data,
    output logic                       front_buf,
    output logic                       frame_done,
    output logic [7:0]                 drop_count
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(FB_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(FB_H - 1);

    render_state_t      state_q;
    obj_t               obj_q [NUM_OBJ];
    pixel_t             bg_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [ADDR_W-1:0]  addr_cnt_q;
    logic               scan_done_q;
    logic               wr_valid_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    pixel_t             wr_data_q;
    logic               last_q;
    logic               front_buf_q;
    logic [7:0]         drop_q;

    logic               hit;
    pixel_t             hit_color;
    pixel_t             pix_d;
    logic               load;
    logic               final_accept;

    obj_hit_test #(
        .NUM_OBJ (NUM_OBJ),
        .COORD_W (COORD_W)
    ) u_hit (
        .x_i     (x_q),
        .y_i     (y_q),
        .objs_i  (obj_q),
        .hit_o   (hit),
        .color_o (hit_color)
    );

    // Stage-1 refill and end-of-frame detection.
    always_comb begin
        pix_d        = hit ? hit_color : bg_q;
        load         = (state_q == RENDER) && (!wr_valid_q || wr_ready);
        final_accept = wr_valid_q && wr_ready && last_q;
    end

    // Frame FSM, scan counters and registered write stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LATCH;
            for (int i = 0; i < NUM_OBJ; i++) obj_q[i] <= '0;
            bg_q        <= BG_DEFAULT;
            x_q         <= '0;
            y_q         <= '0;
            addr_cnt_q  <= '0;
            scan_done_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            last_q      <= 1'b0;
            front_buf_q <= 1'b0;
            drop_q      <= 8'd0;
        end else begin
            case (state_q)
                LATCH: begin
                    for (int i = 0; i < NUM_OBJ; i++) begin
                        obj_q[i].en    <= obj_en[i];
                        obj_q[i].x     <= obj_x[i*COORD_W +: COORD_W];
                        obj_q[i].y     <= obj_y[i*COORD_W +: COORD_W];
                        obj_q[i].w     <= obj_w[i*COORD_W +: COORD_W];
                        obj_q[i].h     <= obj_h[i*COORD_W +: COORD_W];
                        obj_q[i].color <= obj_color[i*12 +: 12];
                    end
                    bg_q        <= bg_color;
                    x_q         <= '0;
                    y_q         <= '0;
                    addr_cnt_q  <= '0;
                    scan_done_q <= 1'b0;
                    wr_valid_q  <= 1'b0;
                    last_q      <= 1'b0;
                    state_q     <= RENDER;
                    if (refresh) drop_q <= sat_inc8(drop_q);
                end
                RENDER: begin
                    if (load) begin
                        if (!scan_done_q) begin
                            wr_valid_q <= 1'b1;
                            wr_addr_q  <= addr_cnt_q;
                            wr_data_q  <= pix_d;
                            last_q     <= (x_q == X_LAST) && (y_q == Y_LAST);
                            addr_cnt_q <= addr_cnt_q + ADDR_W'(1);
                            if (x_q == X_LAST) begin
                                x_q <= '0;
                                if (y_q == Y_LAST) scan_done_q <= 1'b1;
                                else               y_q <= y_q + COORD_W'(1);
                            end else begin
                                x_q <= x_q + COORD_W'(1);
                            end
                        end else begin
                            wr_valid_q <= 1'b0;
                            last_q     <= 1'b0;
                        end
                    end
                    // A refresh landing exactly on the last acceptance still swaps.
                    if (final_accept) begin
                        if (refresh) begin
                            front_buf_q <= ~front_buf_q;
                            state_q     <= LATCH;
                        end else begin
                            state_q     <= WAIT_SWAP;
                        end
                    end else if (refresh) begin
                        drop_q <= sat_inc8(drop_q);
                    end
                end
                WAIT_SWAP: begin
                    wr_valid_q <= 1'b0;
                    if (refresh) begin
                        front_buf_q <= ~front_buf_q;
                        state_q     <= LATCH;
                    end
                end
                default: state_q <= LATCH;
            endcase
        end
    end

    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_buf     = ~front_buf_q;
    assign front_buf  = front_buf_q;
    assign frame_done = final_accept;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_frame_renderer.sv
// tb/tb_frame_renderer.sv - scoreboard bench for frame_renderer on an 8x4 framebuffer
module tb_frame_renderer;

    localparam int NO = 8;
    localparam int CW = 10;
    localparam int AW = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           refresh;
    logic [11:0]    bg_color;
    logic [NO-1:0]  obj_en;
    logic [NO*CW-1:0] obj_x, obj_y, obj_w, obj_h;
    logic [NO*12-1:0] obj_color;
    logic           wr_valid;
    logic           wr_ready;
    logic           wr_buf;
    logic [AW-1:0]  wr_addr;
    logic [11:0]    wr_data;
    logic           front_buf;
    logic           frame_done;
    logic [7:0]     drop_count;

    int total = 0;
    int bad   = 0;
    int stall_cnt = 0;
    logic [17:0] exp_q [$];

    frame_renderer #(
        .FB_W(8), .FB_H(4), .NUM_OBJ(NO), .COORD_W(CW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .refresh(refresh), .bg_color(bg_color),
        .obj_en(obj_en), .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w),
        .obj_h(obj_h), .obj_color(obj_color), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_buf(wr_buf), .wr_addr(wr_addr),
        .wr_data(wr_data), .front_buf(front_buf), .frame_done(frame_done),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Hand-derived frame contents: scenario 0 is plain background,
    // scenario 1 is the object set loaded before the second frame.
    function automatic logic [11:0] exp_data(input int scen, input int a);
        if (scen == 0) return 12'h00F;
        case (a)
            11:             return 12'h0F0;
            10, 12, 18, 19, 20: return 12'hF00;
            31:             return 12'h0FF;
            default:        return 12'h333;
        endcase
    endfunction

    task automatic push_frame(input logic b, input int scen);
        for (int a = 0; a < 32; a++) exp_q.push_back({b, 5'(a), exp_data(scen, a)});
    endtask

    task automatic set_obj(input int i, input logic en, input int x, input int y,
                           input int w, input int h, input logic [11:0] c);
        obj_en[i]           = en;
        obj_x[i*CW +: CW]   = CW'(x);
        obj_y[i*CW +: CW]   = CW'(y);
        obj_w[i*CW +: CW]   = CW'(w);
        obj_h[i*CW +: CW]   = CW'(h);
        obj_color[i*12 +: 12] = c;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (frame_done) begin seen = 1'b1; break; end
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_addr(input string name, input int a);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (wr_valid && wr_addr == AW'(a)) begin seen = 1'b1; break; end
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    // Monitor: pops one expectation per accepted write, checks stall stability.
    logic        prev_stall = 1'b0;
    logic [17:0] st_val;
    always @(negedge clk) begin
        logic [17:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {13'd0, wr_valid, wr_buf, wr_addr, wr_data},
                    {13'd0, 1'b1, st_val});
            prev_stall = wr_valid && !wr_ready;
            if (prev_stall) begin
                stall_cnt++;
                st_val = {wr_buf, wr_addr, wr_data};
            end
            if (wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {14'd0, wr_buf, wr_addr, wr_data}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("write", {14'd0, wr_buf, wr_addr, wr_data}, {14'd0, e});
                    chk("frame_done", 32'(frame_done), 32'(e[16:12] == 5'd31));
                end
            end else if (frame_done) begin
                chk("spurious_frame_done", 32'(frame_done), 32'd0);
            end
        end
    end

    initial begin
        logic stalled;
        rst_n    = 1'b0;
        refresh  = 1'b0;
        wr_ready = 1'b1;
        bg_color = 12'h00F;
        obj_en = '0; obj_x = '0; obj_y = '0; obj_w = '0; obj_h = '0; obj_color = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_front_buf", 32'(front_buf), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_buf", 32'(wr_buf), 32'd1);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);

        // Frame 1: background only; one refresh mid-render counts as a drop.
        push_frame(1'b1, 0);
        rst_n = 1'b1;
        wait_addr("reach_addr5", 5);
        refresh = 1'b1;
        @(posedge clk); #1;
        refresh = 1'b0;
        wait_done("frame1_done");
        repeat (5) @(posedge clk);
        #1;
        chk("f1_idle_valid", 32'(wr_valid), 32'd0);
        chk("f1_drop", 32'(drop_count), 32'd1);
        chk("f1_front", 32'(front_buf), 32'd0);

        // Load object set while waiting for swap.
        bg_color = 12'h333;
        set_obj(0, 1'b1, 2, 1, 3, 2, 12'hF00);
        set_obj(3, 1'b1, 0, 0, 0, 4, 12'hFFF);
        set_obj(4, 1'b1, 5, 0, 3, 0, 12'hEEE);
        set_obj(5, 1'b1, 3, 1, 1, 1, 12'h0F0);
        set_obj(6, 1'b0, 0, 0, 20, 20, 12'hABC);
        set_obj(7, 1'b1, 7, 3, 5, 5, 12'h0FF);
        push_frame(1'b0, 1);
        push_frame(1'b1, 1);
        refresh = 1'b1;
        @(posedge clk); #1;
        refresh = 1'b0;
        chk("swap_front", 32'(front_buf), 32'd1);
        chk("swap_wr_buf", 32'(wr_buf), 32'd0);
        chk("swap_drop", 32'(drop_count), 32'd1);

        // Frame 2: input churn after latch, 3-cycle stall at 13, refresh on final accept.
        stalled = 1'b0;
        stall_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (wr_valid && wr_addr == 5'd2) bg_color = 12'h777;
            if (wr_valid && wr_addr == 5'd25) bg_color = 12'h333;
            if (wr_valid && wr_addr == 5'd13 && !stalled) begin
                stalled = 1'b1;
                wr_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                wr_ready = 1'b1;
            end
            if (wr_valid && wr_addr == 5'd31) begin
                refresh = 1'b1;
                @(posedge clk); #1;
                refresh = 1'b0;
                break;
            end
        end
        chk("stall_cycles", 32'(stall_cnt), 32'd3);
        chk("coinc_front", 32'(front_buf), 32'd0);
        chk("coinc_drop", 32'(drop_count), 32'd1);
        chk("coinc_valid", 32'(wr_valid), 32'd0);

        // Frame 3: reset while pixel 17 is pending.
        wait_addr("reach_addr17", 17);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(wr_valid), 32'd0);
        chk("mid_rst_front", 32'(front_buf), 32'd0);
        chk("mid_rst_drop", 32'(drop_count), 32'd0);
        exp_q.delete();
        push_frame(1'b1, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Frame 4: restart from address 0.
        wait_done("frame4_done");
        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("f4_idle_valid", 32'(wr_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_renderer.md
Name: frame_renderer

Overview:
- Upstream producer for the VGA controller: rasterises a small table of coloured rectangles (game objects) into the back half of a double-buffered framebuffer.
- Tells the controller which half is the front buffer to display.
- Swaps buffers only on the refresh pulse, so the display never shows a partially drawn frame.
- Writes leave through a valid/ready pixel-write port to the framebuffer RAM arbiter.

Parameters:
- FB_W, 640, framebuffer width in pixels (matches visible width).
- FB_H, 480, framebuffer height in pixels.
- NUM_OBJ, 8, number of rectangle slots.
- COORD_W, 10, width of x/y/w/h coordinates.
- ADDR_W, 19, width of wr_addr; must satisfy 2^ADDR_W >= FB_W*FB_H.

Ports:
- clk  in  1  pixel-domain clock.
- rst_n  in  1  asynchronous, active-low reset.
- refresh  in  1  single-cycle pulse, synchronous to clk, at start of vertical blanking.
- bg_color  in  12  background colour {r[3:0],g[3:0],b[3:0]}.
- obj_en  in  NUM_OBJ  per-slot enable.
- obj_x, obj_y  in  NUM_OBJ*COORD_W  top-left corner per slot (slot i at bits [i*COORD_W +: COORD_W]).
- obj_w, obj_h  in  NUM_OBJ*COORD_W  size per slot.
- obj_color  in  NUM_OBJ*12  colour per slot.
- wr_valid  out  1  pixel write request.
- wr_ready  in  1  RAM side accepts the write this cycle.
- wr_buf  out  1  target buffer index (always the back buffer).
- wr_addr  out  ADDR_W  y*FB_W + x.
- wr_data  out  12  pixel colour.
- front_buf  out  1  buffer the controller must display.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted.
- drop_count  out  8  saturating count of refresh pulses missed while rendering.

Behaviour:
- Reset values: front_buf=0, wr_valid=0, wr_buf=1, wr_addr=0, wr_data=0, frame_done=0, drop_count=0; FSM enters LATCH.
- Reset is asynchronous. Asserting it mid-frame abandons the frame; no further writes occur.
- FSM states:
  - LATCH (1 cycle): snapshot all obj_* inputs and bg_color into internal registers; scan x=0, y=0; go to RENDER. Input changes after this cycle do not affect the current frame.
  - RENDER: raster scan, x fastest, 0..FB_W-1, then y 0..FB_H-1.
  - WAIT_SWAP: wr_valid=0; on refresh, toggle front_buf and go to LATCH.
- Two-stage pipeline in RENDER:
  - Stage 0 is the scan counter.
  - Stage 1 is the registered write (wr_addr/wr_data/wr_valid).
  - Latency from counter value to wr_valid is 1 cycle.
  - Stage 1 loads when empty or when the current write is accepted (wr_valid && wr_ready). Counters advance only on that load.
  - Full throughput: 1 pixel/cycle with wr_ready held high.
- Handshake:
  - While wr_valid=1 and wr_ready=0, wr_addr/wr_data/wr_buf hold stable.
  - wr_valid never drops without acceptance, except on reset.
- Hit test: pixel (x,y) is inside slot i iff obj_en[i] && x>=ox && x<ox+ow && y>=oy && y<oy+oh.
  - Sums are computed at COORD_W+1 bits, so there is no wrap.
  - w=0 or h=0 draws nothing.
  - Rectangles extending past FB_W/FB_H are clipped implicitly.
- Priority: the highest-index hitting slot wins; if no slot hits, bg_color.
- Address: wr_addr = y*FB_W + x, maintained incrementally (+1 per accepted pixel, no multiplier); wr_buf = ~front_buf.
- Frame end:
  - Acceptance of pixel (FB_W-1, FB_H-1) pulses frame_done in the same cycle.
  - The FSM enters WAIT_SWAP on the next cycle.
- Refresh in the same cycle as the final acceptance is honoured: front_buf toggles on the next edge and the FSM goes directly to LATCH.
- Refresh while in RENDER (other than on the final acceptance) or in LATCH: no swap; drop_count increments, saturating at 255.
- Refresh while in WAIT_SWAP is never a drop.
- front_buf changes only on a swap.

Decomposition:
- render_pkg holds:
  - pixel_t struct packed {r,g,b : 4 bits each};
  - obj_t struct {en, x, y, w, h, color};
  - render_state_t enum {LATCH, RENDER, WAIT_SWAP};
  - BG_DEFAULT constant.
- One sub-module: obj_hit_test. Combinational; takes x, y and the latched obj_t array, returns hit and pixel_t using the priority rule. It is parameterised by NUM_OBJ and COORD_W and is reusable for collision logic.

Test Plan:
- FB_W=8, FB_H=4, all obj_en=0, bg=12'h00F, wr_ready=1 -> 32 writes, addr 0..31, data 00F, wr_buf=1; frame_done on addr 31; no further writes until refresh.
- Slot0 (x2,y1,w3,h2,F00), slot5 (x3,y1,w1,h1,0F0) -> addr 10=F00, 11=0F0, 12=F00, 18..20=F00, rest bg.
- Deassert wr_ready 3 cycles mid-frame at addr 13 -> wr_valid held, addr 13 and data stable for 3 cycles; no skipped or duplicate address.
- Refresh pulse during RENDER, then again in WAIT_SWAP -> drop_count=1; front_buf 0->1 after the second pulse; next frame writes with wr_buf=0.
- Refresh coincident with final acceptance -> front_buf toggles next cycle, drop_count unchanged, LATCH follows.
- Assert rst_n low at addr 17 -> wr_valid=0 immediately, front_buf=0, drop_count=0; after release the frame restarts at addr 0.
